// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator constants: key codes, sequencer state encoding, operand width
package calc_pkg;

  localparam int          C_CALC_W  = 8;

  localparam logic [3:0]  C_KEY_ADD = 4'hA;
  localparam logic [3:0]  C_KEY_SUB = 4'hB;
  localparam logic [3:0]  C_KEY_CLR = 4'hC;
  localparam logic [3:0]  C_KEY_EQ  = 4'hF;

  localparam logic [2:0]  S_ENTER_A = 3'd0;
  localparam logic [2:0]  S_ENTER_B = 3'd1;
  localparam logic [2:0]  S_COMPUTE = 3'd2;
  localparam logic [2:0]  S_RESULT  = 3'd3;
  localparam logic [2:0]  S_ERROR   = 3'd4;

  typedef logic [3:0] key_t;

  function automatic logic is_digit(input key_t k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/calc_sequencer_bin2bcd.sv
// rtl/calc_sequencer_bin2bcd.sv - signed W+1-bit value to sign plus 3-digit BCD magnitude
module bin2bcd_sm
  import calc_pkg::*;
#(
  parameter int W = C_CALC_W
) (
  input  logic [W:0]  i_value,
  output logic [11:0] o_bcd,
  output logic        o_neg
);

  logic [W:0]  w_mag;
  logic [11:0] w_bcd;

  always_comb begin
    w_mag = i_value[W] ? (~i_value + 1'b1) : i_value;
    w_bcd = '0;
    for (int i = W; i >= 0; i--) begin
      for (int d = 0; d < 3; d++) begin
        if (w_bcd[d*4 +: 4] >= 4'd5) w_bcd[d*4 +: 4] = w_bcd[d*4 +: 4] + 4'd3;
      end
      w_bcd = {w_bcd[10:0], w_mag[i]};
    end
    // Only reachable for W>8: display pins at 999 rather than wrapping.
    if (32'(w_mag) > 32'd999) w_bcd = 12'h999;
  end

  assign o_bcd = w_bcd;
  assign o_neg = i_value[W];

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - operand A / function / operand B / equals sequencer with registered BCD result
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int         W       = C_CALC_W,
  parameter logic [3:0] KEY_ADD = C_KEY_ADD,
  parameter logic [3:0] KEY_SUB = C_KEY_SUB,
  parameter logic [3:0] KEY_CLR = C_KEY_CLR,
  parameter logic [3:0] KEY_EQ  = C_KEY_EQ
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          trig,
  input  logic [3:0]    key,
  input  logic [W-1:0]  operand,
  input  logic          op_valid,
  output logic          entry_clr,
  output logic [W:0]    result,
  output logic [11:0]   res_bcd,
  output logic          res_neg,
  output logic          done,
  output logic          err,
  output logic [2:0]    state_o
);

  logic [2:0]   r_state;
  logic [W-1:0] r_opa;
  logic [W-1:0] r_opb;
  logic         r_func_sub;
  logic [W:0]   r_result;
  logic [11:0]  r_bcd;
  logic         r_neg;
  logic         r_done;
  logic         r_err;
  logic         r_entry_clr;

  logic [W:0]   w_opa_x;
  logic [W:0]   w_opb_x;
  logic [W:0]   w_sum;
  logic [11:0]  w_bcd;
  logic         w_neg;
  logic         w_is_func;

  assign w_opa_x   = {r_opa[W-1], r_opa};
  assign w_opb_x   = {r_opb[W-1], r_opb};
  assign w_sum     = r_func_sub ? (w_opa_x - w_opb_x) : (w_opa_x + w_opb_x);
  assign w_is_func = (key == KEY_ADD) || (key == KEY_SUB);

  bin2bcd_sm #(.W(W)) u_bin2bcd (
    .i_value (w_sum),
    .o_bcd   (w_bcd),
    .o_neg   (w_neg)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state     <= S_ENTER_A;
      r_opa       <= '0;
      r_opb       <= '0;
      r_func_sub  <= 1'b0;
      r_result    <= '0;
      r_bcd       <= '0;
      r_neg       <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_entry_clr <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_entry_clr <= 1'b0;
      // CLR aborts from anywhere except the single COMPUTE cycle; the result stays on display.
      if (trig && (key == KEY_CLR) && (r_state != S_COMPUTE)) begin
        r_state     <= S_ENTER_A;
        r_entry_clr <= 1'b1;
        r_err       <= 1'b0;
        r_opa       <= '0;
        r_opb       <= '0;
      end else begin
        case (r_state)
          S_ENTER_A: begin
            if (trig && w_is_func) begin
              if (op_valid) begin
                r_opa       <= operand;
                r_func_sub  <= (key == KEY_SUB);
                r_entry_clr <= 1'b1;
                r_state     <= S_ENTER_B;
              end else begin
                r_err   <= 1'b1;
                r_state <= S_ERROR;
              end
            end
          end
          S_ENTER_B: begin
            if (trig && (key == KEY_EQ)) begin
              if (op_valid) begin
                r_opb       <= operand;
                r_entry_clr <= 1'b1;
                r_state     <= S_COMPUTE;
              end else begin
                r_err   <= 1'b1;
                r_state <= S_ERROR;
              end
            end else if (trig && w_is_func) begin
              r_func_sub <= (key == KEY_SUB);
            end
          end
          S_COMPUTE: begin
            r_result <= w_sum;
            r_bcd    <= w_bcd;
            r_neg    <= w_neg;
            r_done   <= 1'b1;
            r_state  <= S_RESULT;
          end
          // The digit that leaves RESULT stays upstream as the first digit of A, so no entry_clr.
          S_RESULT: begin
            if (trig && is_digit(key)) r_state <= S_ENTER_A;
          end
          S_ERROR: begin
            r_err <= 1'b1;
          end
          default: r_state <= S_ENTER_A;
        endcase
      end
    end
  end

  assign entry_clr = r_entry_clr;
  assign result    = r_result;
  assign res_bcd   = r_bcd;
  assign res_neg   = r_neg;
  assign done      = r_done;
  assign err       = r_err;
  assign state_o   = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed self-checking bench for calc_sequencer
module tb_calc_sequencer;
  import calc_pkg::*;

  logic        clock = 1'b0;
  logic        clear;
  logic        trig;
  logic [3:0]  key;
  logic [7:0]  operand;
  logic        op_valid;
  logic        entry_clr;
  logic [8:0]  result;
  logic [11:0] res_bcd;
  logic        res_neg;
  logic        done;
  logic        err;
  logic [2:0]  state_o;

  int errors = 0;
  int checks = 0;
  int ec_cnt = 0;
  int done_cnt = 0;
  int snap;

  calc_sequencer dut (
    .clock     (clock),
    .clear     (clear),
    .trig      (trig),
    .key       (key),
    .operand   (operand),
    .op_valid  (op_valid),
    .entry_clr (entry_clr),
    .result    (result),
    .res_bcd   (res_bcd),
    .res_neg   (res_neg),
    .done      (done),
    .err       (err),
    .state_o   (state_o)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (entry_clr === 1'b1) ec_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic press(input logic [3:0] k, input logic [7:0] opnd, input logic v);
    @(negedge clock);
    trig = 1'b1; key = k; operand = opnd; op_valid = v;
    @(negedge clock);
    trig = 1'b0; key = 4'h0;
  endtask

  initial begin
    clear = 1'b1; trig = 1'b0; key = 4'h0; operand = 8'h00; op_valid = 1'b1;
    step(); step();
    clear = 1'b0;
    chk("rst_state", state_o, S_ENTER_A);
    chk("rst_result", result, 9'h000);
    chk("rst_bcd", res_bcd, 12'h000);
    chk("rst_flags", {res_neg, done, err, entry_clr}, 4'b0000);

    // 25 + (-7) = 18
    press(C_KEY_ADD, 8'd25, 1'b1);
    chk("t1_entry_clr_a", entry_clr, 1'b1);
    chk("t1_state_b", state_o, S_ENTER_B);
    press(C_KEY_EQ, 8'hF9, 1'b1);
    chk("t1_state_compute", state_o, S_COMPUTE);
    chk("t1_done_early", done, 1'b0);
    step();
    chk("t1_done", done, 1'b1);
    chk("t1_result", result, 9'd18);
    chk("t1_bcd", res_bcd, 12'h018);
    chk("t1_neg", res_neg, 1'b0);
    chk("t1_state_result", state_o, S_RESULT);
    step();
    chk("t1_done_pulse", done, 1'b0);

    // CLR from RESULT keeps the result; then -99 - 99 = -198
    press(C_KEY_CLR, 8'h00, 1'b1);
    chk("t2_clr_state", state_o, S_ENTER_A);
    chk("t2_clr_result_kept", result, 9'd18);
    step();
    ec_cnt = 0;
    press(C_KEY_SUB, 8'h9D, 1'b1);
    press(C_KEY_EQ, 8'h63, 1'b1);
    step(); step();
    chk("t2_result", result, 9'h13A);
    chk("t2_bcd", res_bcd, 12'h198);
    chk("t2_neg", res_neg, 1'b1);
    chk("t2_entry_clr_count", ec_cnt, 2);

    // invalid operand on function key -> ERROR; EQ ignored; CLR recovers
    press(C_KEY_CLR, 8'h00, 1'b1);
    snap = done_cnt;
    press(C_KEY_ADD, 8'd12, 1'b0);
    chk("t3_err_state", state_o, S_ERROR);
    chk("t3_err", err, 1'b1);
    chk("t3_no_entry_clr", entry_clr, 1'b0);
    press(C_KEY_EQ, 8'd3, 1'b1);
    step();
    chk("t3_eq_ignored", state_o, S_ERROR);
    chk("t3_no_done", done_cnt, snap);
    press(C_KEY_CLR, 8'h00, 1'b1);
    chk("t3_clr_err", err, 1'b0);
    chk("t3_clr_state", state_o, S_ENTER_A);
    chk("t3_clr_pulse", entry_clr, 1'b1);

    // operator replaced: 5 ADD then SUB, 3 -> 2
    press(C_KEY_ADD, 8'd5, 1'b1);
    press(C_KEY_SUB, 8'd0, 1'b1);
    chk("t4_stay_b", state_o, S_ENTER_B);
    press(C_KEY_EQ, 8'd3, 1'b1);
    step();
    chk("t4_result", result, 9'd2);
    chk("t4_bcd", res_bcd, 12'h002);

    // extremes: -128 - 127 = -255, then 127 + 127 = 254
    press(C_KEY_CLR, 8'h00, 1'b1);
    press(C_KEY_SUB, 8'h80, 1'b1);
    press(C_KEY_EQ, 8'h7F, 1'b1);
    step();
    chk("t5_min_result", result, 9'h101);
    chk("t5_min_bcd", {res_neg, res_bcd}, 13'h1255);
    press(C_KEY_CLR, 8'h00, 1'b1);
    press(C_KEY_ADD, 8'h7F, 1'b1);
    press(C_KEY_EQ, 8'h7F, 1'b1);
    step();
    chk("t5_max_result", result, 9'd254);
    chk("t5_max_bcd", {res_neg, res_bcd}, 13'h0254);

    // clear beats simultaneous EQ in ENTER_B
    press(C_KEY_CLR, 8'h00, 1'b1);
    press(C_KEY_ADD, 8'd10, 1'b1);
    @(negedge clock);
    clear = 1'b1; trig = 1'b1; key = C_KEY_EQ; operand = 8'd3; op_valid = 1'b1;
    @(negedge clock);
    clear = 1'b0; trig = 1'b0; key = 4'h0;
    snap = done_cnt;
    chk("t6_state", state_o, S_ENTER_A);
    chk("t6_result", result, 9'h000);
    chk("t6_bcd", res_bcd, 12'h000);
    chk("t6_flags", {res_neg, done, err, entry_clr}, 4'b0000);
    step(); step();
    chk("t6_no_done", done_cnt, snap);

    // RESULT + digit -> ENTER_A with result held; EQ in ENTER_A does nothing
    press(C_KEY_ADD, 8'd100, 1'b1);
    press(C_KEY_EQ, 8'hE4, 1'b1);
    step();
    chk("t7_result", result, 9'd72);
    press(C_KEY_ADD, 8'd1, 1'b1);
    chk("t7_add_ignored", state_o, S_RESULT);
    press(4'd7, 8'd7, 1'b1);
    chk("t7_digit_state", state_o, S_ENTER_A);
    chk("t7_digit_no_clr", entry_clr, 1'b0);
    chk("t7_result_held", result, 9'd72);
    snap = done_cnt;
    press(C_KEY_EQ, 8'd7, 1'b1);
    step(); step();
    chk("t7_eq_state", state_o, S_ENTER_A);
    chk("t7_eq_no_done", done_cnt, snap);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
